// File: rtl/timer_if.sv
// CPU-side memory bus seen by the timer: 16-bit address, 8-bit data,
// level-sensitive write strobe and a combinational read path.
interface timer_if;
    logic [15:0] addr;
    logic        read_en;
    logic        write_en;
    logic [7:0]  wdata;
    logic [7:0]  rdata;

    modport Peripheral_side (
        input  addr,
        input  read_en,
        input  write_en,
        input  wdata,
        output rdata
    );

    modport Cpu_side (
        output addr,
        output read_en,
        output write_en,
        output wdata,
        input  rdata
    );
endinterface

// File: rtl/timer.sv
// DIV/TIMA/TMA/TAC timer: free-running 16-bit divider, falling-edge driven
// TIMA counter and a delayed TMA reload that raises a one-clock interrupt.
module timer #(
    parameter logic [15:0] DIV_INIT = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    timer_if.Peripheral_side      bus,
    output logic                  timer_req
);

    localparam logic [15:0] ADDR_DIV  = 16'hFF04;
    localparam logic [15:0] ADDR_TIMA = 16'hFF05;
    localparam logic [15:0] ADDR_TMA  = 16'hFF06;
    localparam logic [15:0] ADDR_TAC  = 16'hFF07;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        RELOAD
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic [7:0]  tima, tima_nxt;
    logic [7:0]  tma, tma_nxt;
    logic [2:0]  tac;
    logic [2:0]  dly, dly_nxt;
    logic        sig_d;
    logic        tap_bit;
    logic        sig;
    logic        fall;

    logic wr_div, wr_tima, wr_tma, wr_tac;

    assign wr_div  = bus.write_en && (bus.addr == ADDR_DIV);
    assign wr_tima = bus.write_en && (bus.addr == ADDR_TIMA);
    assign wr_tma  = bus.write_en && (bus.addr == ADDR_TMA);
    assign wr_tac  = bus.write_en && (bus.addr == ADDR_TAC);

    always_comb begin
        case (tac[1:0])
            2'b00:   tap_bit = cnt[9];
            2'b01:   tap_bit = cnt[3];
            2'b10:   tap_bit = cnt[5];
            default: tap_bit = cnt[7];
        endcase
    end

    // DIV clears, TAC rewrites and enable drops all look like falling edges here.
    assign sig  = tac[2] & tap_bit;
    assign fall = sig_d & ~sig;

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        state_nxt = state;
        dly_nxt   = dly;
        tima_nxt  = tima;
        tma_nxt   = wr_tma ? bus.wdata : tma;
        timer_req = 1'b0;

        case (state)
            IDLE: begin
                if (wr_tima) begin
                    tima_nxt = bus.wdata;
                end else if (fall) begin
                    if (tima == 8'hFF) begin
                        tima_nxt  = 8'h00;
                        dly_nxt   = 3'd3;
                        state_nxt = DELAY;
                    end else begin
                        tima_nxt = tima + 8'd1;
                    end
                end
            end
            DELAY: begin
                if (wr_tima) begin
                    tima_nxt  = bus.wdata;
                    dly_nxt   = 3'd0;
                    state_nxt = IDLE;
                end else if (dly == 3'd0) begin
                    // TMA is copied on entry so TIMA shows it during the interrupt clock.
                    tima_nxt  = tma;
                    state_nxt = RELOAD;
                end else begin
                    dly_nxt = dly - 3'd1;
                end
            end
            RELOAD: begin
                timer_req = 1'b1;
                state_nxt = IDLE;
                if (wr_tma) begin
                    tima_nxt = bus.wdata;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= DIV_INIT;
            tima  <= 8'h00;
            tma   <= 8'h00;
            tac   <= 3'b000;
            dly   <= 3'd0;
            sig_d <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= wr_div ? 16'h0000 : cnt + 16'd1;
            tima  <= tima_nxt;
            tma   <= tma_nxt;
            dly   <= dly_nxt;
            sig_d <= sig;
            if (wr_tac) begin
                tac <= bus.wdata[2:0];
            end
        end
    end

    always_comb begin
        bus.rdata = 8'h00;
        if (bus.read_en) begin
            case (bus.addr)
                ADDR_DIV:  bus.rdata = cnt[15:8];
                ADDR_TIMA: bus.rdata = tima;
                ADDR_TMA:  bus.rdata = tma;
                ADDR_TAC:  bus.rdata = {5'b11111, tac};
                default:   bus.rdata = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for timer: directed scenarios plus randomized bus
// traffic compared against a cycle-level behavioural model.
module tb_timer;

    localparam logic [15:0] DIV_INIT_TB = 16'h3C00;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic timer_req;

    timer_if bus ();

    timer #(.DIV_INIT(DIV_INIT_TB)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .timer_req (timer_req)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Behavioural model: divider as a plain integer, overflow as a countdown
    // of remaining clocks until the reload happens.
    int unsigned m_cnt;
    logic [7:0]  m_tima, m_tma;
    logic [2:0]  m_tac;
    bit          m_sig_prev;
    int          m_pend;
    bit          m_rel;

    function automatic bit m_sig();
        int b;
        case (m_tac[1:0])
            2'b00:   b = 9;
            2'b01:   b = 3;
            2'b10:   b = 5;
            default: b = 7;
        endcase
        return m_tac[2] && (((m_cnt >> b) & 1) == 1);
    endfunction

    function automatic bit m_fall_next();
        return m_sig_prev && !m_sig();
    endfunction

    function automatic logic [7:0] m_read(input logic [15:0] a);
        case (a)
            16'hFF04: return 8'(m_cnt >> 8);
            16'hFF05: return m_tima;
            16'hFF06: return m_tma;
            16'hFF07: return {5'b11111, m_tac};
            default:  return 8'h00;
        endcase
    endfunction

    task automatic m_reset();
        m_cnt = DIV_INIT_TB; m_tima = 8'h00; m_tma = 8'h00; m_tac = 3'b000;
        m_sig_prev = 1'b0; m_pend = 0; m_rel = 1'b0;
    endtask

    task automatic m_step(input bit we, input logic [15:0] a, input logic [7:0] wd);
        bit s, f, r;
        logic [7:0] t, tm;
        int p;
        s = m_sig();
        f = m_sig_prev && !s;
        t = m_tima; tm = m_tma; p = m_pend; r = 1'b0;
        if (m_rel) begin
            if (we && a == 16'hFF06) t = wd;
        end else if (m_pend > 0) begin
            if (we && a == 16'hFF05) begin
                t = wd; p = 0;
            end else begin
                p = m_pend - 1;
                if (p == 0) begin t = m_tma; r = 1'b1; end
            end
        end else begin
            if (we && a == 16'hFF05) t = wd;
            else if (f) begin
                if (m_tima == 8'hFF) begin t = 8'h00; p = 4; end
                else t = m_tima + 8'd1;
            end
        end
        if (we && a == 16'hFF06) tm = wd;
        if (we && a == 16'hFF07) m_tac = wd[2:0];
        m_cnt = (we && a == 16'hFF04) ? 0 : ((m_cnt + 1) & 32'h0000FFFF);
        m_sig_prev = s; m_tima = t; m_tma = tm; m_pend = p; m_rel = r;
    endtask

    task automatic cycle(input bit we, input logic [15:0] a, input logic [7:0] wd);
        bus.addr = a; bus.write_en = we; bus.wdata = wd; bus.read_en = 1'b0;
        m_step(we, a, wd);
        @(posedge clk); #1;
        bus.write_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 16'h0000, 8'h00);
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        bus.addr = a; bus.read_en = 1'b1;
        #1;
        d = bus.rdata;
        bus.read_en = 1'b0;
    endtask

    task automatic wait_model(input int kind, input int limit, input string name);
        int n = 0;
        while (n < limit && !((kind == 0 && m_pend == 4) || (kind == 1 && m_rel) ||
                              (kind == 2 && m_fall_next() && m_pend == 0 && !m_rel) ||
                              (kind == 3 && m_cnt == 32'h0200))) begin
            idle(1);
            n++;
        end
        if (n >= limit) begin
            total++; bad++;
            $display("FAIL %s: got timeout after %0d clks want event", name, n);
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset = 1'b1;
        bus.addr = 16'h0000; bus.read_en = 1'b0; bus.write_en = 1'b0; bus.wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_reset();
        total++;
        if (timer_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", timer_req); end
        for (int i = 0; i < 6; i++) begin
            logic [15:0] a;
            a = 16'hFF03 + 16'(i);
            rd(a, d);
            total++;
            if (d !== m_read(a)) begin bad++; $display("FAIL reset_read %h: got %h want %h", a, d, m_read(a)); end
        end
    endtask

    task automatic test_div_tick();
        logic [7:0] d;
        cycle(1'b1, 16'hFF04, 8'h00);
        cycle(1'b1, 16'hFF07, 8'h05);
        idle(64);
        rd(16'hFF05, d);
        total++;
        if (d !== 8'h04) begin bad++; $display("FAIL div_tick_tima: got %h want 04", d); end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        cycle(1'b1, 16'hFF06, 8'hAB);
        cycle(1'b1, 16'hFF05, 8'hFF);
        wait_model(0, 64, "overflow_wait");
        for (int k = 0; k < 4; k++) begin
            if (k > 0) idle(1);
            rd(16'hFF05, d);
            total++;
            if (d !== 8'h00) begin bad++; $display("FAIL ovf_zero clk%0d: got %h want 00", k, d); end
            total++;
            if (timer_req !== 1'b0) begin bad++; $display("FAIL ovf_req_early clk%0d: got %b want 0", k, timer_req); end
        end
        idle(1);
        rd(16'hFF05, d);
        total++;
        if (d !== 8'hAB) begin bad++; $display("FAIL ovf_reload: got %h want ab", d); end
        total++;
        if (timer_req !== 1'b1) begin bad++; $display("FAIL ovf_req: got %b want 1", timer_req); end
        idle(1);
        total++;
        if (timer_req !== 1'b0) begin bad++; $display("FAIL ovf_req_drop: got %b want 0", timer_req); end
        rd(16'hFF05, d);
        total++;
        if (d !== 8'hAB) begin bad++; $display("FAIL ovf_hold: got %h want ab", d); end
    endtask

    task automatic test_delay_abort();
        logic [7:0] d;
        cycle(1'b1, 16'hFF05, 8'hFF);
        wait_model(0, 64, "abort_wait");
        idle(1);
        cycle(1'b1, 16'hFF05, 8'h12);
        for (int k = 0; k < 8; k++) begin
            rd(16'hFF05, d);
            total++;
            if (d !== 8'h12) begin bad++; $display("FAIL abort_tima clk%0d: got %h want 12", k, d); end
            total++;
            if (timer_req !== 1'b0) begin bad++; $display("FAIL abort_req clk%0d: got %b want 0", k, timer_req); end
            idle(1);
        end
    endtask

    task automatic test_div_glitch();
        logic [7:0] d, exp_tima;
        cycle(1'b1, 16'hFF07, 8'h04);
        cycle(1'b1, 16'hFF04, 8'h00);
        wait_model(3, 1100, "glitch_wait");
        exp_tima = m_tima + 8'd1;
        cycle(1'b1, 16'hFF04, 8'h5A);
        rd(16'hFF04, d);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL glitch_div: got %h want 00", d); end
        idle(1);
        rd(16'hFF05, d);
        total++;
        if (d !== exp_tima) begin bad++; $display("FAIL glitch_tima: got %h want %h", d, exp_tima); end
    endtask

    task automatic test_tac_read();
        logic [7:0] d;
        cycle(1'b1, 16'hFF07, 8'h06);
        rd(16'hFF07, d);
        total++;
        if (d !== 8'hFE) begin bad++; $display("FAIL tac_read: got %h want fe", d); end
        rd(16'hFF08, d);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL unmapped_read: got %h want 00", d); end
        bus.addr = 16'hFF07; bus.read_en = 1'b0;
        #1;
        total++;
        if (bus.rdata !== 8'h00) begin bad++; $display("FAIL no_read_en: got %h want 00", bus.rdata); end
    endtask

    task automatic test_reload_writes();
        logic [7:0] d;
        cycle(1'b1, 16'hFF07, 8'h05);
        cycle(1'b1, 16'hFF06, 8'hAB);
        cycle(1'b1, 16'hFF05, 8'hFF);
        wait_model(1, 64, "reload_wait_a");
        cycle(1'b1, 16'hFF05, 8'h55);
        rd(16'hFF05, d);
        total++;
        if (d !== 8'hAB) begin bad++; $display("FAIL reload_tima_write: got %h want ab", d); end
        cycle(1'b1, 16'hFF05, 8'hFF);
        wait_model(1, 64, "reload_wait_b");
        cycle(1'b1, 16'hFF06, 8'h77);
        rd(16'hFF05, d);
        total++;
        if (d !== 8'h77) begin bad++; $display("FAIL reload_tma_tima: got %h want 77", d); end
        rd(16'hFF06, d);
        total++;
        if (d !== 8'h77) begin bad++; $display("FAIL reload_tma: got %h want 77", d); end
    endtask

    task automatic test_write_vs_inc();
        logic [7:0] d;
        cycle(1'b1, 16'hFF05, 8'h30);
        wait_model(2, 64, "fall_wait");
        cycle(1'b1, 16'hFF05, 8'h40);
        rd(16'hFF05, d);
        total++;
        if (d !== 8'h40) begin bad++; $display("FAIL write_wins: got %h want 40", d); end
        cycle(1'b1, 16'hFF05, 8'h40);
        rd(16'hFF05, d);
        total++;
        if (d !== 8'h40) begin bad++; $display("FAIL write_held: got %h want 40", d); end
    endtask

    task automatic test_random();
        logic [15:0] a, ra;
        logic [7:0] wd, d;
        bit we;
        for (int i = 0; i < 1500; i++) begin
            we = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 11))
                0:       a = 16'hFF03;
                1:       a = 16'hFF04;
                2, 3, 4: a = 16'hFF05;
                5, 6:    a = 16'hFF06;
                7, 8, 9: a = 16'hFF07;
                10:      a = 16'hFF08;
                default: a = 16'h0000;
            endcase
            wd = 8'($urandom);
            if (a == 16'hFF05 && $urandom_range(0, 1) == 1) wd = 8'hFC | 8'($urandom_range(0, 3));
            if (a == 16'hFF07 && $urandom_range(0, 2) != 0) wd[2] = 1'b1;
            cycle(we, a, wd);
            total++;
            if (timer_req !== m_rel) begin bad++; $display("FAIL rand_req @%0d: got %b want %b", i, timer_req, m_rel); end
            rd(16'hFF05, d);
            total++;
            if (d !== m_tima) begin bad++; $display("FAIL rand_tima @%0d: got %h want %h", i, d, m_tima); end
            ra = 16'hFF03 + 16'($urandom_range(0, 5));
            rd(ra, d);
            total++;
            if (d !== m_read(ra)) begin bad++; $display("FAIL rand_read %h @%0d: got %h want %h", ra, i, d, m_read(ra)); end
        end
    endtask

    task automatic test_reset_reload();
        logic [7:0] d;
        cycle(1'b1, 16'hFF07, 8'h05);
        cycle(1'b1, 16'hFF06, 8'hAB);
        cycle(1'b1, 16'hFF05, 8'hFF);
        wait_model(1, 64, "rst_reload_wait");
        #2 reset = 1'b1;
        #1;
        total++;
        if (timer_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", timer_req); end
        rd(16'hFF05, d);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL rst_tima: got %h want 00", d); end
        rd(16'hFF06, d);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL rst_tma: got %h want 00", d); end
        @(posedge clk); #1 reset = 1'b0;
        m_reset();
        for (int k = 0; k < 10; k++) begin
            idle(1);
            total++;
            if (timer_req !== 1'b0) begin bad++; $display("FAIL rst_after_req clk%0d: got %b want 0", k, timer_req); end
        end
    endtask

    initial begin
        test_reset();
        test_div_tick();
        test_overflow();
        test_delay_abort();
        test_div_glitch();
        test_tac_read();
        test_reload_writes();
        test_write_vs_inc();
        test_random();
        test_reset_reload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
